// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: y = act(bias + sum a_i*w_i) using one shared multiplier.
// Define NEURON_MAC_SAT_EN to clamp the accumulator to WIDTH bits before activation.
module neuron_mac_seq #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int N_IN     = 3,
    parameter int ACT_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   a_flat,
    input  logic [N_IN*WIDTH-1:0]   w_flat,
    input  logic [WIDTH-1:0]        bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        y,
    output logic                    busy
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(64'd1 << FRAC);
    localparam logic [WIDTH-1:0] HALF = WIDTH'(64'd1 << (FRAC - 1));
    localparam logic [WIDTH-1:0] T2   = WIDTH'((64'd19 << FRAC) >> 3);
    localparam logic [WIDTH-1:0] T5   = WIDTH'(64'd5 << FRAC);
    localparam logic [WIDTH-1:0] C2   = WIDTH'((64'd27 << FRAC) >> 5);
    localparam logic [WIDTH-1:0] C1   = WIDTH'((64'd5 << FRAC) >> 3);

    typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic signed [AW-1:0]     acc;
    logic signed [WIDTH-1:0]  a_r [N_IN];
    logic signed [WIDTH-1:0]  w_r [N_IN];
    logic signed [AW-1:0]     prod;
    logic signed [AW-1:0]     term;
    logic signed [WIDTH-1:0]  red;
    logic [WIDTH-1:0]         ax;
    logic [WIDTH-1:0]         f;
    logic [WIDTH-1:0]         sig;
    logic [WIDTH-1:0]         act;

    assign prod = a_r[cnt] * w_r[cnt];
    assign term = prod >>> FRAC;

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [AW-1:0] MAXV =
        {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        red = acc[WIDTH-1:0];
        if (acc > MAXV)
            red = {1'b0, {(WIDTH-1){1'b1}}};
        else if (acc < MINV)
            red = {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    assign red = acc[WIDTH-1:0];
`endif

    // Piecewise-linear sigmoid on |x|, mirrored for x < 0; exact 0.5 at x = 0.
    always_comb begin
        ax = red[WIDTH-1] ? -red : red;
        f  = HALF;
        unique case (1'b1)
            (ax >= T5):  f = ONE;
            (ax >= T2 && ax < T5):  f = (ax >> 5) + C2;
            (ax >= ONE && ax < T2): f = (ax >> 3) + C1;
            (ax < ONE):  f = (ax >> 2) + HALF;
        endcase
        sig = red[WIDTH-1] ? ONE - f : f;
        act = (ACT_MODE == 1) ? red : sig;
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                a_r[i] <= '0;
                w_r[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_IN; i++) begin
                            a_r[i] <= a_flat[i*WIDTH +: WIDTH];
                            w_r[i] <= w_flat[i*WIDTH +: WIDTH];
                        end
                        acc   <= {{WIDTH{bias[WIDTH-1]}}, bias};
                        cnt   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + term;
                    if (cnt == CW'(N_IN - 1))
                        state <= ACT;
                    else
                        cnt <= cnt + 1'b1;
                end
                ACT: begin
                    y         <= act;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
